// File: rtl/logic_pll_lock_timer_if.sv
// logic_pll_lock_timer_if
// Groups the config (load) stream and the timer (expiry event) stream of
// logic_pll_lock_timer. The slave modport is the timer's view; the master
// modport is the view of whoever loads counts and consumes expiry events.
interface logic_pll_lock_timer_if #(
    parameter int WIDTH = 32
);
    localparam int KEEP_W = (WIDTH + 7) / 8;

    // Load stream: each beat carries a count value N.
    logic              config_tvalid;
    logic              config_tready;
    logic [WIDTH-1:0]  config_tdata;
    logic              config_tlast;

    // Expiry event stream: each beat carries the N that produced the event.
    logic              timer_tvalid;
    logic              timer_tready;
    logic [WIDTH-1:0]  timer_tdata;
    logic              timer_tlast;
    logic [KEEP_W-1:0] timer_tstrb;
    logic [KEEP_W-1:0] timer_tkeep;
    logic              timer_tuser;
    logic              timer_tdest;
    logic              timer_tid;

    modport slave (
        input  config_tvalid, config_tdata, config_tlast, timer_tready,
        output config_tready, timer_tvalid, timer_tdata, timer_tlast,
        output timer_tstrb, timer_tkeep, timer_tuser, timer_tdest, timer_tid
    );

    modport master (
        output config_tvalid, config_tdata, config_tlast, timer_tready,
        input  config_tready, timer_tvalid, timer_tdata, timer_tlast,
        input  timer_tstrb, timer_tkeep, timer_tuser, timer_tdest, timer_tid
    );
endinterface

// File: rtl/logic_pll_lock_timer.sv
// logic_pll_lock_timer
// Programmable lock timer: a load of N arms a countdown of N*PRESCALER aclk
// cycles (N=0 counts as 1); on expiry an event carrying N is offered on the
// timer stream and held until the consumer accepts it. A new load always wins
// and restarts the count, discarding any pending or in-flight event.
//
// Optional feature macro: LOGIC_PLL_LOCK_TIMER_PERIODIC_EN
//   undefined : one-shot, an accepted event returns the timer to IDLE.
//   defined   : an accepted event re-arms with the latched N so events repeat
//               every N*PRESCALER cycles plus any time the event was stalled.
module logic_pll_lock_timer #(
    parameter int WIDTH     = 32,
    parameter int PRESCALER = 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    logic_pll_lock_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [15:0]      PRESC_LAST = 16'(PRESCALER - 1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [15:0]      presc_q, presc_d;
    logic [WIDTH-1:0] data_q,  data_d;

    logic             cfg_ready;
    logic             load;
    logic [WIDTH-1:0] load_count;
    logic             unused_tlast;

    // The load stream never stalls except while reset is held.
    assign cfg_ready    = ~areset;
    assign load         = bus.config_tvalid & cfg_ready;
    assign load_count   = (bus.config_tdata == '0) ? ONE : bus.config_tdata;
    assign unused_tlast = bus.config_tlast;

    assign bus.config_tready = cfg_ready;
    assign bus.timer_tvalid  = (state_q == EXPIRED);
    assign bus.timer_tdata   = data_q;
    assign bus.timer_tlast   = 1'b1;
    assign bus.timer_tstrb   = '1;
    assign bus.timer_tkeep   = '1;
    assign bus.timer_tuser   = 1'b0;
    assign bus.timer_tdest   = 1'b0;
    assign bus.timer_tid     = 1'b0;

`ifdef LOGIC_PLL_LOCK_TIMER_PERIODIC_EN
    logic [WIDTH-1:0] reload_count;
    assign reload_count = (data_q == '0) ? ONE : data_q;
`endif

    // Next-state logic: a load overrides everything, otherwise count down in
    // COUNT and wait for the consumer in EXPIRED.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        data_d  = data_q;

        if (load) begin
            state_d = COUNT;
            count_d = load_count;
            presc_d = '0;
            data_d  = bus.config_tdata;
        end else begin
            case (state_q)
                COUNT: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        count_d = (count_q > ONE) ? (count_q - ONE) : '0;
                        if (count_q <= ONE) begin
                            state_d = EXPIRED;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                EXPIRED: begin
                    if (bus.timer_tready) begin
`ifdef LOGIC_PLL_LOCK_TIMER_PERIODIC_EN
                        // The cycle the event was visible counts as the first
                        // tick of the next period, keeping the period exactly
                        // N*PRESCALER when the consumer never stalls.
                        if (PRESC_LAST == 16'd0) begin
                            presc_d = '0;
                            if (reload_count == ONE) begin
                                count_d = '0;
                                state_d = EXPIRED;
                            end else begin
                                count_d = reload_count - ONE;
                                state_d = COUNT;
                            end
                        end else begin
                            count_d = reload_count;
                            presc_d = 16'd1;
                            state_d = COUNT;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset to an idle, empty timer.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_logic_pll_lock_timer.sv
// tb_logic_pll_lock_timer
// Drives a PRESCALER=1 and a PRESCALER=4 timer with identical stimulus and
// compares both against a deadline-based reference model plus fixed
// expectations for the named scenarios.
module tb_logic_pll_lock_timer;
    localparam int W = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cfg_valid;
    logic [W-1:0]  cfg_data;
    logic          cfg_last;
    logic          tready;

    int total = 0;
    int bad   = 0;

    logic_pll_lock_timer_if #(.WIDTH(W)) bus1 ();
    logic_pll_lock_timer_if #(.WIDTH(W)) bus4 ();

    assign bus1.config_tvalid = cfg_valid;
    assign bus1.config_tdata  = cfg_data;
    assign bus1.config_tlast  = cfg_last;
    assign bus1.timer_tready  = tready;
    assign bus4.config_tvalid = cfg_valid;
    assign bus4.config_tdata  = cfg_data;
    assign bus4.config_tlast  = cfg_last;
    assign bus4.timer_tready  = tready;

    logic_pll_lock_timer #(.WIDTH(W), .PRESCALER(1)) dut1 (
        .aclk(aclk), .areset(areset), .bus(bus1.slave));
    logic_pll_lock_timer #(.WIDTH(W), .PRESCALER(4)) dut4 (
        .aclk(aclk), .areset(areset), .bus(bus4.slave));

    always #5 aclk = ~aclk;

    // Reference model: absolute-cycle deadlines rather than counters.
    longint       cyc = 0;
    longint       presc_of [2] = '{1, 4};
    bit           m_armed [2] = '{0, 0};
    bit           m_pending [2] = '{0, 0};
    longint       m_deadline [2] = '{0, 0};
    logic [W-1:0] m_data [2] = '{'0, '0};

    function automatic longint eff(input logic [W-1:0] n);
        return (n == '0) ? 64'd1 : longint'(n);
    endfunction

    // Expected event for a tready=1 scenario whose first event is at step e.
    function automatic bit fire(input int i, input int e, input int p);
`ifdef LOGIC_PLL_LOCK_TIMER_PERIODIC_EN
        return (i >= e) && (((i - e) % p) == 0);
`else
        return (i == e) && (p > 0);
`endif
    endfunction

    always @(posedge aclk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (areset) begin
                m_armed[d] = 0;
                m_pending[d] = 0;
                m_data[d] = '0;
            end else if (cfg_valid) begin
                m_armed[d] = 1;
                m_pending[d] = 0;
                m_data[d] = cfg_data;
                m_deadline[d] = cyc + eff(cfg_data) * presc_of[d];
            end else if (m_pending[d] && tready) begin
                m_pending[d] = 0;
`ifdef LOGIC_PLL_LOCK_TIMER_PERIODIC_EN
                m_deadline[d] = cyc - 1 + eff(m_data[d]) * presc_of[d];
                if (m_deadline[d] == cyc) m_pending[d] = 1;
                else m_armed[d] = 1;
`endif
            end else if (m_armed[d] && cyc == m_deadline[d]) begin
                m_pending[d] = 1;
                m_armed[d] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic load_n(input logic [W-1:0] n);
        cfg_valid = 1'b1;
        cfg_data  = n;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1; cfg_valid = 1'b1; cfg_data = 7; cfg_last = 1'b0; tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus1.timer_tvalid !== 1'b0 || bus1.timer_tdata !== '0 || bus1.config_tready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_p1 valid=%b data=%0d ready=%b expected 0/0/0",
                         bus1.timer_tvalid, bus1.timer_tdata, bus1.config_tready);
            end
            total++;
            if (bus4.timer_tvalid !== 1'b0 || bus4.timer_tdata !== '0 || bus4.config_tready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_p4 valid=%b data=%0d ready=%b expected 0/0/0",
                         bus4.timer_tvalid, bus4.timer_tdata, bus4.config_tready);
            end
        end
        areset = 1'b0; cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus1.config_tready !== 1'b1 || bus1.timer_tvalid !== 1'b0 ||
                bus4.config_tready !== 1'b1 || bus4.timer_tvalid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL post_reset ready=%b/%b valid=%b/%b expected 1/1 0/0",
                         bus1.config_tready, bus4.config_tready, bus1.timer_tvalid, bus4.timer_tvalid);
            end
        end
    endtask

    task automatic test_basic();
        tready = 1'b1;
        load_n(5);
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i <= 6) begin
                total++;
                if (bus1.timer_tvalid !== fire(i, 5, 5)) begin
                    bad++;
                    $display("[TB] FAIL basic_valid step=%0d got=%b expected=%b", i, bus1.timer_tvalid, fire(i, 5, 5));
                end
            end
            if (i == 5) begin
                total++;
                if (bus1.timer_tdata !== 5 || bus1.timer_tlast !== 1'b1 || bus1.timer_tkeep !== '1 ||
                    bus1.timer_tstrb !== '1 || bus1.timer_tuser !== 1'b0 || bus1.timer_tdest !== 1'b0 ||
                    bus1.timer_tid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL basic_beat data=%0d last=%b keep=%h expected data=5 last=1 keep=all-ones",
                             bus1.timer_tdata, bus1.timer_tlast, bus1.timer_tkeep);
                end
            end
            total++;
            if (bus4.timer_tvalid !== fire(i, 20, 20) || bus4.timer_tvalid !== m_pending[1]) begin
                bad++;
                $display("[TB] FAIL basic_p4 step=%0d got=%b expected=%b", i, bus4.timer_tvalid, m_pending[1]);
            end
        end
    endtask

    task automatic test_zero();
        tready = 1'b1;
        load_n(0);
        total++;
        if (bus1.timer_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_early got=%b expected=0", bus1.timer_tvalid);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++;
            if (bus1.timer_tvalid !== fire(i, 1, 1) || (i == 1 && bus1.timer_tdata !== '0)) begin
                bad++;
                $display("[TB] FAIL zero_p1 step=%0d valid=%b data=%0d expected valid=%b data=0",
                         i, bus1.timer_tvalid, bus1.timer_tdata, fire(i, 1, 1));
            end
            total++;
            if (bus4.timer_tvalid !== m_pending[1] || bus4.timer_tdata !== m_data[1]) begin
                bad++;
                $display("[TB] FAIL zero_p4 step=%0d valid=%b data=%0d expected valid=%b data=%0d",
                         i, bus4.timer_tvalid, bus4.timer_tdata, m_pending[1], m_data[1]);
            end
        end
    endtask

    task automatic test_stall();
        tready = 1'b0;
        load_n(3);
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i <= 13) begin
                total++;
                if (bus1.timer_tvalid !== (i >= 3 && i <= 12) ||
                    (bus1.timer_tvalid === 1'b1 && bus1.timer_tdata !== 3)) begin
                    bad++;
                    $display("[TB] FAIL stall_p1 step=%0d valid=%b data=%0d expected valid=%b data=3",
                             i, bus1.timer_tvalid, bus1.timer_tdata, (i >= 3 && i <= 12));
                end
            end
            total++;
            if (bus4.timer_tvalid !== m_pending[1] || bus4.timer_tdata !== m_data[1]) begin
                bad++;
                $display("[TB] FAIL stall_p4 step=%0d valid=%b data=%0d expected valid=%b data=%0d",
                         i, bus4.timer_tvalid, bus4.timer_tdata, m_pending[1], m_data[1]);
            end
            if (i == 12) tready = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        tready = 1'b0;
        load_n(2);
        tick();
        tick();
        total++;
        if (bus1.timer_tvalid !== 1'b1 || bus1.timer_tdata !== 2) begin
            bad++;
            $display("[TB] FAIL b2b_first valid=%b data=%0d expected valid=1 data=2", bus1.timer_tvalid, bus1.timer_tdata);
        end
        tready = 1'b1;
        load_n(4);
        total++;
        if (bus1.timer_tvalid !== 1'b0 || bus1.timer_tdata !== 4) begin
            bad++;
            $display("[TB] FAIL b2b_next valid=%b data=%0d expected valid=0 data=4", bus1.timer_tvalid, bus1.timer_tdata);
        end
        for (int j = 1; j <= 20; j++) begin
            tick();
            total++;
            if (bus1.timer_tvalid !== fire(j, 4, 4)) begin
                bad++;
                $display("[TB] FAIL b2b_p1 step=%0d got=%b expected=%b", j, bus1.timer_tvalid, fire(j, 4, 4));
            end
            total++;
            if (bus4.timer_tvalid !== m_pending[1] || bus4.timer_tdata !== m_data[1]) begin
                bad++;
                $display("[TB] FAIL b2b_p4 step=%0d valid=%b data=%0d expected valid=%b data=%0d",
                         j, bus4.timer_tvalid, bus4.timer_tdata, m_pending[1], m_data[1]);
            end
        end
    endtask

    task automatic test_reload();
        tready = 1'b1;
        load_n(100);
        for (int i = 1; i <= 50; i++) begin
            tick();
            total++;
            if (bus1.timer_tvalid !== 1'b0 || bus4.timer_tvalid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reload_early step=%0d got=%b/%b expected=0/0", i, bus1.timer_tvalid, bus4.timer_tvalid);
            end
        end
        load_n(2);
        for (int j = 1; j <= 70; j++) begin
            tick();
            total++;
            if (bus1.timer_tvalid !== fire(j, 2, 2) || (j == 2 && bus1.timer_tdata !== 2)) begin
                bad++;
                $display("[TB] FAIL reload_p1 step=%0d valid=%b data=%0d expected valid=%b data=2",
                         j, bus1.timer_tvalid, bus1.timer_tdata, fire(j, 2, 2));
            end
            total++;
            if (bus4.timer_tvalid !== fire(j, 8, 8) || bus4.timer_tvalid !== m_pending[1]) begin
                bad++;
                $display("[TB] FAIL reload_p4 step=%0d got=%b expected=%b", j, bus4.timer_tvalid, m_pending[1]);
            end
        end
    endtask

    task automatic test_prescaler_reset();
        tready = 1'b1;
        load_n(3);
        for (int i = 1; i <= 24; i++) begin
            if (i == 6) areset = 1'b1;
            tick();
            areset = 1'b0;
            total++;
            if (bus4.timer_tvalid !== 1'b0 || (i >= 6 && bus4.timer_tdata !== '0)) begin
                bad++;
                $display("[TB] FAIL presc_reset_p4 step=%0d valid=%b data=%0d expected valid=0",
                         i, bus4.timer_tvalid, bus4.timer_tdata);
            end
            total++;
            if (bus1.timer_tvalid !== m_pending[0] || bus1.timer_tdata !== m_data[0]) begin
                bad++;
                $display("[TB] FAIL presc_reset_p1 step=%0d valid=%b data=%0d expected valid=%b data=%0d",
                         i, bus1.timer_tvalid, bus1.timer_tdata, m_pending[0], m_data[0]);
            end
        end
    endtask

    task automatic test_repeat();
        tready = 1'b1;
        load_n(3);
        for (int i = 1; i <= 40; i++) begin
            tick();
            total++;
            if (bus4.timer_tvalid !== fire(i, 12, 12) || bus1.timer_tvalid !== fire(i, 3, 3)) begin
                bad++;
                $display("[TB] FAIL repeat step=%0d got=%b/%b expected=%b/%b",
                         i, bus1.timer_tvalid, bus4.timer_tvalid, fire(i, 3, 3), fire(i, 12, 12));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            areset    = ($urandom_range(0, 63) == 0);
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_data  = W'($urandom_range(0, 12));
            cfg_last  = 1'($urandom);
            tready    = ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if (bus1.timer_tvalid !== m_pending[0] || bus1.timer_tdata !== m_data[0] ||
                bus1.config_tready !== !areset) begin
                bad++;
                $display("[TB] FAIL random_p1 step=%0d valid=%b data=%0d ready=%b expected valid=%b data=%0d",
                         i, bus1.timer_tvalid, bus1.timer_tdata, bus1.config_tready, m_pending[0], m_data[0]);
            end
            total++;
            if (bus4.timer_tvalid !== m_pending[1] || bus4.timer_tdata !== m_data[1] ||
                bus4.config_tready !== !areset) begin
                bad++;
                $display("[TB] FAIL random_p4 step=%0d valid=%b data=%0d ready=%b expected valid=%b data=%0d",
                         i, bus4.timer_tvalid, bus4.timer_tdata, bus4.config_tready, m_pending[1], m_data[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_back_to_back();
        test_reload();
        test_prescaler_reset();
        test_repeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_pll_lock_timer.md
LOGIC_PLL_LOCK_TIMER -- requirements
Module: logic_pll_lock_timer

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32: bit width of the count value on both streams.
REQ-002 The block SHALL have a parameter PRESCALER, default 1 (range 1..65535): aclk cycles per count tick.
REQ-003 aclk  input  1  single clock; all logic SHALL be clocked on the rising edge.
REQ-004 areset  input  1  reset; synchronous and active-high, sampled on the rising edge of aclk.
REQ-005 config_tvalid  input  1  load request.
REQ-006 config_tready  output  1  load accept; SHALL be constant 1 outside reset.
REQ-007 config_tdata  input  WIDTH  count value N to load.
REQ-008 config_tlast  input  1  ignored; every beat is a complete load.
REQ-009 timer_tvalid  output  1  expiry event pending.
REQ-010 timer_tready  input  1  consumer accepts the expiry event.
REQ-011 timer_tlast  output  1  SHALL be constant 1; tstrb/tkeep all-ones; tuser/tdest/tid zero.
REQ-012 timer_tdata  output  WIDTH  value N that produced this expiry.

Function
REQ-013 The block SHALL have the states IDLE, COUNT and EXPIRED.
REQ-014 A config handshake (config_tvalid=1) SHALL load the counter with max(N,1), latch N for timer_tdata, clear the prescaler, and enter COUNT, from any state.
REQ-015 In COUNT, the counter SHALL decrement once every PRESCALER cycles, and SHALL enter EXPIRED when the decrement takes it from 1 to 0.
REQ-016 The latency SHALL be as follows: a load at edge k SHALL cause timer_tvalid=1 after edge k+N*PRESCALER, and N=0 SHALL behave as N=1.
REQ-017 In EXPIRED, timer_tvalid SHALL be 1 and timer_tdata SHALL be stable until the handshake; an event SHALL NOT be dropped while timer_tready=0.
REQ-018 An expiry handshake without a simultaneous load SHALL go to IDLE (or as REQ-025 when the periodic feature is enabled).
REQ-019 A simultaneous expiry handshake and load SHALL complete the event and start the new count, with timer_tvalid=0 on the next cycle.
REQ-020 A load while in EXPIRED without timer_tready SHALL discard the pending event and restart counting.
REQ-021 A load during COUNT SHALL restart the count with the new N, and the old count SHALL produce no event.
REQ-022 timer_tvalid SHALL be 0 in IDLE and COUNT; the counter SHALL never wrap below 0.

Reset
REQ-023 While areset=1, the block SHALL hold the state IDLE, counter=0, prescaler=0, timer_tvalid=0, timer_tdata=0 and config_tready=0, and a load presented during reset SHALL be ignored.
REQ-024 Reset asserted mid-count or in EXPIRED SHALL abort the operation, with no event emitted after the reset is released.

Configuration
REQ-025 With the macro LOGIC_PLL_LOCK_TIMER_PERIODIC_EN defined, an expiry handshake without a load SHALL reload the latched N and re-enter COUNT, so events occur every N*PRESCALER cycles plus the stall time.
REQ-026 With LOGIC_PLL_LOCK_TIMER_PERIODIC_EN undefined, the timer SHALL be one-shot per REQ-018, and no reload logic SHALL be synthesized.

Verification
REQ-027 The bench SHALL cover: PRESCALER=1, load N=5 at edge 10, timer_tready=1 -> timer_tvalid high only in the cycle after edge 15, with timer_tdata=5 and timer_tlast=1.
REQ-028 The bench SHALL cover: load N=0 -> timer_tvalid after exactly 1 cycle, with timer_tdata=0.
REQ-029 The bench SHALL cover: load N=3 with timer_tready=0 for 10 cycles after expiry -> timer_tvalid held 10 cycles, tdata=3, then IDLE one cycle after the handshake.
REQ-030 The bench SHALL cover: expiry handshake plus load N=4 in the same cycle -> timer_tvalid=0 next cycle and high again 4 cycles later with tdata=4.
REQ-031 The bench SHALL cover: load N=100, reload N=2 at count 50 -> single event 2 cycles after the reload, and no event at the original 100.
REQ-032 The bench SHALL cover: PRESCALER=4, N=3, areset pulsed at cycle 6 -> no event, and all outputs at their reset values; with PERIODIC_EN and no reset -> events every 12 cycles while timer_tready=1.
